// File: rtl/mag_arb.sv
// mag_arb: round-robin scheduler sharing one magnitude estimator among NCH
// requesters. Grants are combinational, operands and a channel tag are
// registered at the grant edge, and the tag rides alongside the estimator
// pipeline so each result lands in its own channel's output register.
module mag_arb #(
    parameter int NCH = 4,
    parameter int LAT = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [NCH-1:0]   req,
    input  logic [8*NCH-1:0] x_in,
    input  logic [8*NCH-1:0] y_in,
    output logic [NCH-1:0]   ack,
    output logic [7:0]       est_x,
    output logic [7:0]       est_y,
    output logic             est_iv,
    input  logic [7:0]       est_mag,
    input  logic             est_ov,
    output logic [8*NCH-1:0] mag_out,
    output logic [NCH-1:0]   mag_v,
    output logic             busy,
    output logic             err
);

    typedef struct packed {
        logic       v;
        logic [2:0] id;
    } tag_t;

    // The estimator's own valid pipe is not reset, so its output is ignored
    // for this many cycles after reset release.
    localparam logic [7:0] SETTLE = 8'(LAT + 1);

    logic [2:0]          last_q;
    logic                gnt_v;
    logic [2:0]          gnt_id;
    int                  idx;
    logic [7:0]          sel_x;
    logic [7:0]          sel_y;
    logic [7:0]          est_x_q;
    logic [7:0]          est_y_q;
    tag_t                issue_q;
    tag_t                pipe_q [LAT];
    tag_t                final_tag;
    logic [NCH-1:0][7:0] mag_q;
    logic [NCH-1:0]      mag_v_q;
    logic [7:0]          settle_q;
    logic                err_q;
    logic                chk_en;
    logic                mismatch;
    logic                busy_w;

    // Pick the first requester after last_q in circular order.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves it unassigned and infers a latch.
        gnt_v  = 1'b0;
        gnt_id = last_q;
        idx    = 0;
        for (int off = 1; off <= NCH; off++) begin
            idx = int'(last_q) + off;
            if (idx >= NCH) idx = idx - NCH;
            for (int k = 0; k < NCH; k++) begin
                if (!gnt_v && en && req[k] && (k == idx)) begin
                    gnt_v  = 1'b1;
                    gnt_id = 3'(k);
                end
            end
        end
    end

    // One-hot grant pulse and operand mux for the granted channel.
    always_comb begin
        ack   = '0;
        sel_x = '0;
        sel_y = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_v && (gnt_id == 3'(k))) begin
                ack[k] = 1'b1;
                sel_x  = x_in[8*k +: 8];
                sel_y  = y_in[8*k +: 8];
            end
        end
    end

    // Issue stage: capture granted operands and start the channel tag.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of its sources.
        if (!rstn) begin
            last_q  <= 3'(NCH - 1);
            est_x_q <= '0;
            est_y_q <= '0;
            issue_q <= '0;
        end else if (gnt_v) begin
            last_q  <= gnt_id;
            est_x_q <= sel_x;
            est_y_q <= sel_y;
            issue_q <= '{v: 1'b1, id: gnt_id};
        end else begin
            issue_q <= '0;
        end
    end

    // Tag pipe: LAT stages aligned with the estimator latency, no stall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < LAT; s++) pipe_q[s] <= '0;
        end else begin
            pipe_q[0] <= issue_q;
            for (int s = 1; s < LAT; s++) pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign final_tag = pipe_q[LAT-1];

    // Writeback: route the emerging magnitude to the tagged channel.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: mag_q is reset explicitly because every channel field must
        // read zero out of reset; a plain storage array would not need one.
        if (!rstn) begin
            mag_q   <= '0;
            mag_v_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (final_tag.v && (final_tag.id == 3'(k))) begin
                    mag_q[k]   <= est_mag;
                    mag_v_q[k] <= 1'b1;
                end else begin
                    mag_v_q[k] <= 1'b0;
                end
            end
        end
    end

    // Self-check: after settling, est_ov must track the final tag valid.
    assign chk_en   = (settle_q == SETTLE);
    assign mismatch = chk_en && (est_ov != final_tag.v);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            settle_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (!chk_en) settle_q <= settle_q + 8'd1;
            err_q <= err_q | mismatch;
        end
    end

    // Busy while the issue stage or any tag stage holds a valid entry.
    always_comb begin
        busy_w = issue_q.v;
        for (int s = 0; s < LAT; s++) busy_w = busy_w | pipe_q[s].v;
    end

    assign est_x   = est_x_q;
    assign est_y   = est_y_q;
    assign est_iv  = issue_q.v;
    assign mag_out = mag_q;
    assign mag_v   = mag_v_q;
    assign busy    = busy_w;
    // The live mismatch is folded in so the flag rises in the very cycle the
    // disagreement is seen; err_q keeps it set afterwards.
    assign err     = err_q | mismatch;

endmodule
